// File: rtl/rf_arb_pkg.sv
// Shared types and default sizes for the register-file write arbiter.
// Used by rf_write_arbiter and rr_priority_picker.
package rf_arb_pkg;

    typedef enum logic {
        RF_ARB_CLEAR,
        RF_ARB_ARB
    } rf_arb_state_e;

    localparam int RF_ARB_N_REQ  = 4;
    localparam int RF_ARB_ADDR_W = 5;
    localparam int RF_ARB_DATA_W = 32;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set valid bit at or above ptr,
// wrapping modulo N_REQ; returns one-hot grant and encoded index.
module rr_priority_picker
    import rf_arb_pkg::*;
#(
    parameter int N_REQ = RF_ARB_N_REQ,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int               pos;
    logic [IDX_W-1:0] sel;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = 0;
        sel     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            sel = IDX_W'(pos);
            if (!any_o && valid_i[sel]) begin
                any_o        = 1'b1;
                grant_o[sel] = 1'b1;
                idx_o        = sel;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: zero-fill sweep after reset, then round-robin.
// RF_ARB_DROP_X0_EN: when defined, granted ARB writes to address 0 are suppressed.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int N_REQ  = RF_ARB_N_REQ,
    parameter int ADDR_W = RF_ARB_ADDR_W,
    parameter int DATA_W = RF_ARB_DATA_W,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    wr_ena,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic [IDX_W-1:0]        grant_id,
    output logic                    init_done
);

    rf_arb_state_e     state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              wr_ena_q, wr_ena_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;

    logic [N_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_priority_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign sel_addr = req_addr[pick_idx*ADDR_W +: ADDR_W];
    assign sel_data = req_data[pick_idx*DATA_W +: DATA_W];

    // Grants are only exposed once the sweep has finished.
    assign req_ready = (state_q == RF_ARB_ARB) ? pick_grant : '0;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        wr_ena_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        unique case (state_q)
            RF_ARB_CLEAR: begin
                wr_ena_d  = 1'b1;
                wr_addr_d = clr_cnt_q;
                wr_data_d = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) begin
                    state_d = RF_ARB_ARB;
                end
            end
            RF_ARB_ARB: begin
                if (pick_any) begin
`ifdef RF_ARB_DROP_X0_EN
                    wr_ena_d = |sel_addr;
`else
                    wr_ena_d = 1'b1;
`endif
                    wr_addr_d  = sel_addr;
                    wr_data_d  = sel_data;
                    grant_id_d = pick_idx;
                    if (pick_idx == IDX_W'(N_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = pick_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_d = RF_ARB_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RF_ARB_CLEAR;
            clr_cnt_q  <= '0;
            rr_ptr_q   <= '0;
            wr_ena_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_ena_q   <= wr_ena_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign wr_ena    = wr_ena_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign grant_id  = grant_id_q;
    assign init_done = (state_q == RF_ARB_ARB);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized bench for rf_write_arbiter against a cycle-count/queue-level model.
// Honours RF_ARB_DROP_X0_EN when defined on the command line.
module tb_rf_write_arbiter;

    localparam int N    = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            wr_ena;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [1:0]      grant_id;
    logic            init_done;

    rf_write_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_ena    (wr_ena),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // requester-side pending writes
    bit          rv [N];
    logic [4:0]  ra [N];
    logic [31:0] rd [N];

    // reference model
    int          since_rst;
    int          ptr;
    logic        e_ena;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    int          e_gid;
    logic        e_init;
    logic [31:0] m_rf [NREG];
    logic [31:0] d_rf [NREG];
    int          gseq [$];

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic raise(input int i, input bit dup);
        if (!rv[i]) begin
            rv[i] = 1'b1;
            ra[i] = dup ? 5'($urandom_range(0, 3)) : 5'($urandom);
            rd[i] = $urandom;
        end
    endtask

    task automatic step(input logic r);
        int g;
        int j;
        logic [N-1:0] e_rdy;
        @(negedge clk);
        rst = r;
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = rv[i];
            req_addr[i*AW +: AW] = ra[i];
            req_data[i*DW +: DW] = rd[i];
        end
        #1;
        g = -1;
        if (!r && since_rst >= NREG) begin
            for (int k = 0; k < N; k++) begin
                j = (ptr + k) % N;
                if (g < 0 && rv[j]) g = j;
            end
        end
        e_rdy = '0;
        if (g >= 0) e_rdy[g] = 1'b1;
        if (!r) check("req_ready", req_ready, e_rdy);
        if (r) begin
            e_ena = 0; e_addr = 0; e_data = 0; e_gid = 0; e_init = 0;
            since_rst = 0;
            ptr = 0;
        end else if (since_rst < NREG) begin
            e_ena  = 1'b1;
            e_addr = 5'(since_rst);
            e_data = 0;
            since_rst++;
            e_init = (since_rst >= NREG);
        end else if (g >= 0) begin
`ifdef RF_ARB_DROP_X0_EN
            e_ena = (ra[g] != 0);
`else
            e_ena = 1'b1;
`endif
            e_addr = ra[g];
            e_data = rd[g];
            e_gid  = g;
            ptr    = (g + 1) % N;
            gseq.push_back(g);
        end else begin
            e_ena = 1'b0;
        end
        if (e_ena) m_rf[e_addr] = e_data;
        @(posedge clk);
        #1;
        check("wr_ena", wr_ena, e_ena);
        check("wr_addr", wr_addr, e_addr);
        check("wr_data", wr_data, e_data);
        check("grant_id", grant_id, e_gid);
        check("init_done", init_done, e_init);
        if (wr_ena === 1'b1) d_rf[wr_addr] = wr_data;
        if (g >= 0) rv[g] = 1'b0;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        since_rst = 0;
        ptr = 0;
        e_ena = 0; e_addr = 0; e_data = 0; e_gid = 0; e_init = 0;
        for (int i = 0; i < N; i++) begin
            rv[i] = 0; ra[i] = 0; rd[i] = 0;
        end
        for (int i = 0; i < NREG; i++) begin
            m_rf[i] = 32'h0;
            d_rf[i] = 32'h0;
        end

        // reset, idle sweep, one idle ARB cycle
        step(1'b1);
        step(1'b1);
        for (int c = 0; c < NREG + 1; c++) step(1'b0);

        // requester 2 alone
        rv[2] = 1'b1; ra[2] = 5'd7; rd[2] = 32'hDEADBEEF;
        step(1'b0);
        check("req2_addr", wr_addr, 64'd7);
        check("req2_data", wr_data, 64'hDEADBEEF);

        // all valid for 8 cycles: grants rotate from the pointer
        gseq.delete();
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) raise(i, 1'b0);
            step(1'b0);
        end
        for (int c = 1; c < gseq.size(); c++) begin
            check("rotate", gseq[c], (gseq[c-1] + 1) % N);
        end
        clear_reqs();

        // requester 1 waits through a sweep
        step(1'b1);
        rv[1] = 1'b1; ra[1] = 5'd9; rd[1] = 32'h1234_5678;
        for (int c = 0; c < NREG + 1; c++) step(1'b0);
        check("req1_after_clear", wr_addr, 64'd9);

        // reset at sweep address 12
        step(1'b1);
        for (int c = 0; c < 12; c++) step(1'b0);
        step(1'b1);
        check("midsweep_ena", wr_ena, 64'd0);
        for (int c = 0; c < NREG; c++) step(1'b0);

        // address-0 write
        rv[0] = 1'b1; ra[0] = 5'd0; rd[0] = 32'd5;
        step(1'b0);

        // randomized traffic with duplicates and occasional resets
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) != 0) raise(i, $urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 199) == 0) begin
                clear_reqs();
                step(1'b1);
            end else begin
                step(1'b0);
            end
        end
        clear_reqs();
        for (int c = 0; c < NREG + 2; c++) step(1'b0);

        for (int i = 0; i < NREG; i++) check("rf_contents", d_rf[i], m_rf[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
